// File: rtl/fp16_pkg.sv
// fp16_pkg: shared binary16 field widths, class and FSM state encodings
package fp16_pkg;
    localparam int EXP_BITS  = 5;
    localparam int FRAC_BITS = 10;
    localparam int BIAS      = 15;
    localparam int EXP_W     = 7;
    localparam int MAN_W     = FRAC_BITS + 1;
    localparam int CNT_W     = 4;
    typedef enum logic [2:0] {NORMAL, ZERO, SUB, INF, NAN} fp16_class_t;
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/fp16_unpack_norm_if.sv
// fp16_unpack_norm_if: operand handshake and unpacked result bundle
interface fp16_unpack_norm_if import fp16_pkg::*; ;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      X;
    logic             out_valid;
    logic             out_ready;
    logic             Xs;
    logic [EXP_W-1:0] Xe;
    logic [MAN_W-1:0] Xm;
    logic             Xzero;
    logic             Xsub;
    logic             Xinf;
    logic             Xnan;
    logic             Xsnan;
    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, Xs, Xe, Xm, Xzero, Xsub, Xinf, Xnan, Xsnan
    );
    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, Xs, Xe, Xm, Xzero, Xsub, Xinf, Xnan, Xsnan
    );
endinterface

// File: rtl/fp16_classify.sv
// fp16_classify: splits a binary16 word into fields and its IEEE class
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]          x,
    output fp16_class_t          cls,
    output logic                 sign,
    output logic [EXP_BITS-1:0]  exp_f,
    output logic [FRAC_BITS-1:0] frac_f
);
    // field extraction and class decode from the all-zero / all-one exponent cases
    always_comb begin
        sign   = x[EXP_BITS+FRAC_BITS];
        exp_f  = x[FRAC_BITS +: EXP_BITS];
        frac_f = x[FRAC_BITS-1:0];
        cls    = ~|exp_f ? (~|frac_f ? ZERO : SUB) :
                 &exp_f  ? (~|frac_f ? INF  : NAN) : NORMAL;
    end
endmodule

// File: rtl/fp16_unpack_norm.sv
// fp16_unpack_norm: unpacks a binary16 operand and normalizes subnormals one bit per cycle
module fp16_unpack_norm
    import fp16_pkg::*;
(
    input logic               clk,
    input logic               reset_n,
    fp16_unpack_norm_if.slave bus
);
    state_t                   state_q, state_d;
    fp16_class_t              cls_q, cls_d;
    logic                     xs_q, xs_d;
    logic signed [EXP_W-1:0]  xe_q, xe_d;
    logic [MAN_W-1:0]         xm_q, xm_d;
    logic                     snan_q, snan_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    fp16_class_t              c_cls;
    logic                     c_sign;
    logic [EXP_BITS-1:0]      c_exp;
    logic [FRAC_BITS-1:0]     c_frac;
    logic signed [EXP_W-1:0]  dec_xe;
    logic [MAN_W-1:0]         dec_xm;
    logic                     accept;

    fp16_classify u_classify (
        .x      (bus.X),
        .cls    (c_cls),
        .sign   (c_sign),
        .exp_f  (c_exp),
        .frac_f (c_frac)
    );

    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = state_q == DONE;
    assign bus.Xs        = xs_q;
    assign bus.Xe        = xe_q;
    assign bus.Xm        = xm_q;
    assign bus.Xzero     = cls_q == ZERO;
    assign bus.Xsub      = cls_q == SUB;
    assign bus.Xinf      = cls_q == INF;
    assign bus.Xnan      = cls_q == NAN;
    assign bus.Xsnan     = snan_q;

    // initial exponent/significand for the incoming word; subnormals start at 1-BIAS with hidden bit 0
    always_comb begin
        dec_xe = (c_cls == NORMAL) ? EXP_W'(c_exp) - EXP_W'(BIAS) :
                 (c_cls == ZERO)   ? '0 :
                 (c_cls == SUB)    ? EXP_W'(1 - BIAS) : EXP_W'(BIAS + 1);
        dec_xm = (c_cls == ZERO) ? '0 :
                 (c_cls == INF)  ? MAN_W'(1) << FRAC_BITS :
                 (c_cls == SUB)  ? {1'b0, c_frac} : {1'b1, c_frac};
    end

    // next state: load on accept, shift while normalizing, retire from DONE when consumed
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        xm_d    = xm_q;
        snan_d  = snan_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = (c_cls == SUB) ? NORM : DONE;
            cls_d   = c_cls;
            xs_d    = c_sign;
            xe_d    = dec_xe;
            xm_d    = dec_xm;
            snan_d  = (c_cls == NAN) & ~c_frac[FRAC_BITS-1];
            cnt_d   = '0;
        end else if (state_q == NORM) begin
            xm_d    = xm_q << 1;
            xe_d    = xe_q - EXP_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = xm_q[MAN_W-2] ? DONE : NORM;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    // state and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cls_q   <= NORMAL;
            xs_q    <= 1'b0;
            xe_q    <= '0;
            xm_q    <= '0;
            snan_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            xm_q    <= xm_d;
            snan_q  <= snan_d;
            cnt_q   <= cnt_d;
        end
    end

    // a nonzero subnormal never needs more shifts than fraction bits
    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n) cnt_q <= CNT_W'(FRAC_BITS));
endmodule

// File: tb/tb_fp16_unpack_norm.sv
// tb_fp16_unpack_norm: randomized scoreboard bench for the fp16 unpack/normalize stage
module tb_fp16_unpack_norm;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fp16_unpack_norm_if bus();

    fp16_unpack_norm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        xs;
        int          xe;
        logic [10:0] xm;
        logic [4:0]  fl;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          force_rdy = 2;
    logic        first = 1'b1;
    exp_t        cur;
    logic [23:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: random, or pinned by the main sequence
    always @(posedge clk) begin
        #1;
        bus.out_ready = (force_rdy == 2) ? ($urandom % 4 != 0) : force_rdy[0];
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // reference: value-level decode; a subnormal F*2^-24 renormalizes to exponent msb(F)-24
    function automatic exp_t model(logic [15:0] x, int acc);
        exp_t r;
        int e = int'(x[14:10]);
        int f = int'(x[9:0]);
        int p = 0;
        r.xs = x[15]; r.acc = acc; r.lat = 1; r.fl = 5'b00000;
        if (e == 0 && f == 0) begin
            r.xe = 0; r.xm = 11'h000; r.fl = 5'b10000;
        end else if (e == 0) begin
            for (int i = 0; i < 10; i++) if (f >= (1 << i)) p = i;
            r.xe = p - 24; r.xm = 11'(f << (10 - p)); r.fl = 5'b01000; r.lat = 1 + 10 - p;
        end else if (e == 31) begin
            r.xe = 16;
            r.xm = (f == 0) ? 11'h400 : 11'(1024 + f);
            r.fl = (f == 0) ? 5'b00100 : (f < 512 ? 5'b00011 : 5'b00010);
        end else begin
            r.xe = e - 15; r.xm = 11'(1024 + f);
        end
        return r;
    endfunction

    function automatic logic [23:0] outs();
        return {bus.Xs, bus.Xe, bus.Xm, bus.Xzero, bus.Xsub, bus.Xinf, bus.Xnan, bus.Xsnan};
    endfunction

    // drive one operand (called at posedge+1), wait for acceptance, record the expectation
    task automatic send(logic [15:0] x);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.X = x;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 for X=%h", x);
        end else begin
            q.push_back(model(x, cyc));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        @(posedge clk); #1;
    endtask

    // monitor: check each new result, its latency, and hold stability while stalled
    always @(negedge clk) begin
        if (!reset_n) begin
            first = 1'b1;
        end else if (bus.out_valid) begin
            if (first) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out: got result %h expected none", outs());
                end else begin
                    cur = q.pop_front();
                    check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    check("xs", 32'(bus.Xs), 32'(cur.xs));
                    check("xe", 32'($signed(bus.Xe)), 32'(cur.xe));
                    check("xm", 32'(bus.Xm), 32'(cur.xm));
                    check("flags", 32'({bus.Xzero, bus.Xsub, bus.Xinf, bus.Xnan, bus.Xsnan}), 32'(cur.fl));
                end
                snap = outs();
                first = 1'b0;
            end else begin
                check("hold", 32'(outs()), 32'(snap));
            end
            check("in_ready_done", 32'(bus.in_ready), 32'(bus.out_ready));
            if (bus.out_ready) first = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [15:0] dir[7] = '{16'h3C00, 16'h0001, 16'h0200, 16'h8000, 16'hFC00, 16'h7E00, 16'h7C01};
    logic [15:0] x;

    initial begin
        bus.in_valid = 1'b0;
        bus.X = 16'h0000;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_outputs", 32'(outs()), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (dir[i]) begin
            send(dir[i]);
            repeat ($urandom % 2) begin @(posedge clk); #1; end
        end
        drain();

        force_rdy = 0;
        @(posedge clk); #1;
        send(16'h3C00);
        repeat (5) @(posedge clk);
        force_rdy = 1;
        #1;
        send(16'hC000);
        force_rdy = 2;
        drain();

        for (int i = 0; i < 150; i++) begin
            x = 16'($urandom);
            if ($urandom % 3 == 0) x[14:10] = 5'd0;
            send(x);
            repeat ($urandom % 3) begin @(posedge clk); #1; end
        end
        drain();

        send(16'h0001);
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_outputs", 32'(outs()), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(16'h3800);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
